// File: rtl/board_guess_checker.sv
// Memory-tile game checker: reveals the captured board for SHOW_CYCLES, then scores presses to WIN/LOSE.
// Outputs decode registered state only; a press shows its effect one cycle after its strobe edge.
module board_guess_checker #(
  parameter int SHOW_CYCLES = 50000000,
  parameter int CNT_W       = 26,
  parameter int MAX_MISS    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] board,
  input  logic       board_valid,
  input  logic [2:0] tile_sel,
  input  logic       tile_press,
  output logic [7:0] display,
  output logic [7:0] hits,
  output logic [2:0] miss_cnt,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHOW  = 3'd1,
    ST_GUESS = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [2:0]       MISS_LIM  = 3'(MAX_MISS);

  state_t           state_q, state_d;
  logic [7:0]       target_q, target_d;
  logic [7:0]       hits_q, hits_d;
  logic [2:0]       miss_q, miss_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      target_q <= 8'h00;
      hits_q   <= 8'h00;
      miss_q   <= 3'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      hits_q   <= hits_d;
      miss_q   <= miss_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    hits_d   = hits_q;
    miss_d   = miss_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (board_valid && (board != 8'h00)) begin
          target_d = board;
          hits_d   = 8'h00;
          miss_d   = 3'd0;
          cnt_d    = '0;
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = ST_GUESS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GUESS: begin
        if (tile_press) begin
          // Repeat hits fall through both branches and leave everything unchanged.
          if (target_q[tile_sel]) begin
            if (!hits_q[tile_sel]) begin
              hits_d = hits_q | (8'h01 << tile_sel);
              if (hits_d == target_q) state_d = ST_WIN;
            end
          end else if (miss_q < MISS_LIM) begin
            miss_d = miss_q + 3'd1;
            if (miss_d == MISS_LIM) state_d = ST_LOSE;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (!board_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    display = 8'h00;
    busy    = 1'b0;
    win     = 1'b0;
    lose    = 1'b0;
    case (state_q)
      ST_SHOW: begin
        display = target_q;
        busy    = 1'b1;
      end
      ST_GUESS: begin
        display = hits_q;
        busy    = 1'b1;
      end
      ST_WIN: begin
        display = target_q;
        win     = 1'b1;
      end
      ST_LOSE: begin
        display = target_q;
        lose    = 1'b1;
      end
      default: display = 8'h00;
    endcase
  end

  assign hits     = hits_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_board_guess_checker.sv
// Bench for board_guess_checker: directed game scenarios plus randomized play against a behavioural model.
module tb_board_guess_checker;

  localparam int SC = 4;
  localparam int MM = 2;
  localparam int P_IDLE = 0, P_SHOW = 1, P_GUESS = 2, P_WIN = 3, P_LOSE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] board;
  logic       board_valid;
  logic [2:0] tile_sel;
  logic       tile_press;
  logic [7:0] display;
  logic [7:0] hits;
  logic [2:0] miss_cnt;
  logic       busy;
  logic       win;
  logic       lose;

  int checks = 0;
  int failures = 0;

  int         m_ph;
  logic [7:0] m_tgt;
  logic [7:0] m_hits;
  int         m_miss;
  int         m_left;

  board_guess_checker #(.SHOW_CYCLES(SC), .CNT_W(3), .MAX_MISS(MM)) dut (
    .clk(clk), .reset(reset), .board(board), .board_valid(board_valid),
    .tile_sel(tile_sel), .tile_press(tile_press), .display(display), .hits(hits),
    .miss_cnt(miss_cnt), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_tgt = 8'h00; m_hits = 8'h00; m_miss = 0; m_left = 0;
  endtask

  // Game rules applied once per clock edge using the inputs present at that edge.
  task automatic model_edge();
    case (m_ph)
      P_IDLE: if (board_valid && board != 8'h00) begin
        m_tgt = board; m_hits = 8'h00; m_miss = 0; m_left = SC; m_ph = P_SHOW;
      end
      P_SHOW: begin
        m_left--;
        if (m_left == 0) m_ph = P_GUESS;
      end
      P_GUESS: if (tile_press) begin
        if (m_tgt[tile_sel]) m_hits[tile_sel] = 1'b1;
        else m_miss++;
        if (m_hits == m_tgt) m_ph = P_WIN;
        else if (m_miss >= MM) m_ph = P_LOSE;
      end
      default: if (!board_valid) m_ph = P_IDLE;
    endcase
  endtask

  task automatic check_all(input string ctx);
    logic [7:0] e_disp;
    e_disp = (m_ph == P_GUESS) ? m_hits : (m_ph == P_IDLE) ? 8'h00 : m_tgt;
    chk({ctx, ".display"}, display, e_disp);
    chk({ctx, ".hits"}, hits, m_hits);
    chk({ctx, ".miss_cnt"}, miss_cnt, m_miss);
    chk({ctx, ".busy"}, busy, (m_ph == P_SHOW || m_ph == P_GUESS));
    chk({ctx, ".win"}, win, (m_ph == P_WIN));
    chk({ctx, ".lose"}, lose, (m_ph == P_LOSE));
  endtask

  task automatic step(input string ctx);
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge();
    #1;
    check_all(ctx);
  endtask

  task automatic press(input logic [2:0] sel);
    tile_sel = sel; tile_press = 1'b1;
    step("press");
    tile_press = 1'b0;
  endtask

  initial begin
    int shown;
    reset = 1'b0; board = 8'h00; board_valid = 1'b0; tile_sel = 3'd0; tile_press = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    step("reset"); step("reset");
    reset = 1'b1;
    step("idle");

    // Reveal window, presses during SHOW ignored.
    board = 8'hA5; board_valid = 1'b1;
    step("show");
    shown = (display == 8'hA5 && busy) ? 1 : 0;
    tile_press = 1'b1; tile_sel = 3'd0;
    repeat (3) begin
      step("show");
      if (display == 8'hA5 && busy) shown++;
    end
    tile_press = 1'b0;
    step("guess");
    if (display == 8'hA5 && busy) shown++;
    step("guess");
    chk("show_len", shown, 4);
    chk("guess_blank", display, 8'h00);
    chk("show_press_hits", hits, 8'h00);
    press(3'd1); press(3'd3);
    chk("a5_lose", lose, 1'b1);
    board_valid = 1'b0;
    step("to_idle");

    // Win with a repeat hit.
    board = 8'h81; board_valid = 1'b1;
    step("cap81"); board_valid = 1'b0;
    repeat (4) step("show81");
    press(3'd0);
    chk("win.hit1", hits, 8'h01);
    press(3'd0);
    chk("win.repeat_hits", hits, 8'h01);
    chk("win.repeat_miss", miss_cnt, 3'd0);
    press(3'd7);
    chk("win.hits", hits, 8'h81);
    chk("win.flag", win, 1'b1);
    chk("win.display", display, 8'h81);

    // Replay gating: held-high valid must not restart.
    board = 8'h3C; board_valid = 1'b1;
    repeat (3) step("hold");
    chk("gate.stay_win", win, 1'b1);
    board_valid = 1'b0;
    step("gate.drop");
    chk("gate.idle_win", win, 1'b0);
    board_valid = 1'b1;
    step("gate.restart");
    chk("gate.display", display, 8'h3C);
    chk("gate.hits", hits, 8'h00);
    chk("gate.busy", busy, 1'b1);
    board_valid = 1'b0;
    repeat (4) step("show3c");
    press(3'd0); press(3'd1);
    step("lose3c");

    // Lose and saturate.
    board = 8'h01; board_valid = 1'b1;
    step("cap01"); board_valid = 1'b0;
    repeat (4) step("show01");
    press(3'd3);
    chk("lose.miss1", miss_cnt, 3'd1);
    press(3'd5);
    chk("lose.miss2", miss_cnt, 3'd2);
    chk("lose.flag", lose, 1'b1);
    chk("lose.display", display, 8'h01);
    press(3'd0); press(3'd6);
    chk("lose.sat", miss_cnt, 3'd2);
    chk("lose.nohit", hits, 8'h00);
    step("to_idle2");

    // Zero board stays idle.
    board = 8'h00; board_valid = 1'b1;
    repeat (3) step("zero");
    chk("zero.busy", busy, 1'b0);
    chk("zero.display", display, 8'h00);
    board_valid = 1'b0;

    // Async reset mid-GUESS.
    board = 8'h81; board_valid = 1'b1;
    step("cap_ar"); board_valid = 1'b0;
    repeat (4) step("show_ar");
    press(3'd0);
    chk("arst.pre_hits", hits, 8'h01);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("arst.now");
    chk("arst.display", display, 8'h00);
    step("arst.hold");
    reset = 1'b1;
    step("arst.idle");
    chk("arst.busy", busy, 1'b0);

    // Randomized play.
    for (int n = 0; n < 3000; n++) begin
      if (!board_valid && $urandom_range(0, 2) == 0)
        board = (8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) board_valid = ~board_valid;
      if ($urandom_range(0, 30) == 0) board = 8'h00;
      tile_press = ($urandom_range(0, 2) == 0);
      tile_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) != 0) begin
        for (int k = 0; k < 8; k++) if (board[k] && $urandom_range(0, 1) == 0) tile_sel = 3'(k);
      end
      step("rand");
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        #1 model_reset();
        check_all("rand.arst");
        step("rand.arst");
        reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_guess_checker.md
Name: board_guess_checker

Overview:
- Downstream consumer of the generated 8-tile board pattern. Shows the pattern for a fixed reveal time, then blanks it.
- Then accepts the player's tile presses, marking hits and counting misses, and declares a win or a loss.
- Drives the 8 tile LEDs and the win/lose status for the top-level game controller.

Parameters:
- SHOW_CYCLES, 50000000, reveal duration in clk cycles (1 s at 50 MHz); must be >= 1.
- CNT_W, 26, width of the reveal counter; must satisfy 2^CNT_W > SHOW_CYCLES.
- MAX_MISS, 2, number of wrong presses that causes a loss; range 1..7.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- board  input  8  target pattern; bit i set = tile i lit
- board_valid  input  1  level; board is stable and non-zero while high
- tile_sel  input  3  index of the pressed tile
- tile_press  input  1  single-cycle press strobe, already debounced upstream
- display  output  8  tile LED drive
- hits  output  8  tiles correctly found so far
- miss_cnt  output  3  wrong presses so far
- busy  output  1  high in SHOW and GUESS
- win  output  1  high in WIN
- lose  output  1  high in LOSE

Behaviour:
- Reset (async, active-low): state=IDLE, target=0, hits=0, miss_cnt=0, reveal counter=0.
  - All outputs are 0 during and after reset.
  - Reset asserted mid-game aborts the game the same way.
- States: IDLE, SHOW, GUESS, WIN, LOSE.
- IDLE:
  - If board_valid=1 and board!=0: capture board into target, clear the counter, hits and miss_cnt, and go to SHOW on the next edge.
  - If board==0 while board_valid=1: stay in IDLE.
- SHOW:
  - display=target, busy=1.
  - Counter increments each cycle. When counter==SHOW_CYCLES-1, go to GUESS, so display=target holds for exactly SHOW_CYCLES cycles.
  - tile_press is ignored in SHOW.
- GUESS: display=hits, busy=1. On tile_press, with bit b=tile_sel:
  - target[b]=1 and hits[b]=0 (hit): set hits[b] on the next edge.
  - target[b]=1 and hits[b]=1 (repeat hit): ignored, no miss counted.
  - target[b]=0 (miss): miss_cnt+1 on the next edge.
  - Win check: if the post-update hits==target, go to WIN in the same edge. win is visible 1 cycle after the winning press.
  - Loss check: if the post-update miss_cnt==MAX_MISS, go to LOSE in the same edge.
  - A single press cannot be both a hit and a miss.
- WIN: display=target, win=1, busy=0.
- LOSE: display=target, lose=1, busy=0. miss_cnt holds its final value.
- Leaving WIN/LOSE: both states wait for board_valid=0, then return to IDLE.
  - A new game therefore needs board_valid to drop and rise again.
  - This prevents immediate replay of a held-high board_valid.
- board/board_valid changes outside IDLE are ignored; target is latched only in IDLE.
- miss_cnt saturates at MAX_MISS and never wraps. hits only ever gains bits during a game.
- All outputs are registered or decoded from registered state, with no combinational path from tile_press to any output.

Test Plan (SHOW_CYCLES=4, MAX_MISS=2):
1. Reveal window:
   - Stimulus: reset low then high, board=8'hA5, board_valid=1.
   - Response: display=8'hA5 for exactly 4 cycles with busy=1, then display=8'h00 in GUESS. Presses during SHOW leave hits=0.
2. Win:
   - Stimulus: board=8'h81; press tile 0, tile 0 again, then tile 7.
   - Response: hits=8'h01 after the first press, unchanged and miss_cnt=0 after the repeat, then hits=8'h81 and win=1 one cycle after the tile-7 press, with display=8'h81.
3. Lose:
   - Stimulus: board=8'h01; press tile 3, then tile 5.
   - Response: miss_cnt=1 after the first press, then miss_cnt=2, lose=1, display=8'h01. Further presses change nothing.
4. Replay gating:
   - Stimulus: after a WIN, hold board_valid=1, then drop it for 1 cycle and raise it with board=8'h3C.
   - Response: stays in WIN while held high, returns to IDLE, then starts SHOW with display=8'h3C and hits/miss_cnt cleared.
5. Zero board:
   - Stimulus: board_valid=1 with board=8'h00.
   - Response: remains IDLE, busy=0, display=8'h00.
6. Async reset mid-GUESS:
   - Stimulus: assert reset between clock edges after one hit.
   - Response: all outputs go to 0 immediately, without waiting for a clock edge; after release the block is in IDLE.
